// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, scheduler state type and the double-dabble nibble-correction helper
package bcd_pkg;
  localparam int BIN_W = 8;
  localparam int BCD_W = 12;
  localparam int SHIFT_W = 20;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sched_state_t;
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] x);
    logic [BCD_W-1:0] r;
    r = x;
    for (int i = 0; i < BCD_W / 4; i++)
      r[4*i+:4] = x[4*i+:4] >= 4'd5 ? x[4*i+:4] + 4'd3 : x[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/bcd_dd_core.sv
// bcd_dd_core: double-dabble shifter; start loads din, en shifts one bit, last flags the 8th shift, q is the BCD field
module bcd_dd_core
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [BIN_W-1:0] din,
  output logic [BCD_W-1:0] q,
  output logic             last
);
  logic [SHIFT_W-1:0] sr;
  logic [2:0]         cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= {{BCD_W{1'b0}}, din};
      cnt <= '0;
    end else if (en) begin
      sr  <= {add3_nibbles(sr[SHIFT_W-1:BIN_W]), sr[BIN_W-1:0]} << 1;
      cnt <= cnt + 3'd1;
    end
  assign q = sr[SHIFT_W-1:BIN_W];
  assign last = en && cnt == 3'd7;
endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin sharing of one binary-to-BCD core among N_REQ requesters (req/data in, ack/bcd/bcd_vld/bcd_id/busy out)
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BIN_W-1:0]     data,
  output logic [N_REQ-1:0]           ack,
  output logic [BCD_W-1:0]           bcd,
  output logic                       bcd_vld,
  output logic [$clog2(N_REQ)-1:0]   bcd_id,
  output logic                       busy
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int SW = ID_W + 1;
  sched_state_t     state, state_nxt;
  logic [ID_W-1:0]  ptr, id, gnt_id;
  logic [SW-1:0]    s;
  logic             gnt_vld, start, shift_en, fin, last;
  logic [BCD_W-1:0] core_q;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    s       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + SW'(k);
      s = s >= SW'(N_REQ) ? s - SW'(N_REQ) : s;
      if (req[s[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = s[ID_W-1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (gnt_vld ? SHIFT : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) :
                bcd_vld ? IDLE : DONE;
  always_comb begin
    start    = state == IDLE && gnt_vld;
    shift_en = state == SHIFT;
    fin      = state == DONE && !bcd_vld;
    busy     = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id      <= '0;
      ptr     <= '0;
      ack     <= '0;
      bcd     <= '0;
      bcd_vld <= 1'b0;
      bcd_id  <= '0;
    end else begin
      if (start) id <= gnt_id;
      ack     <= fin ? {{(N_REQ-1){1'b0}}, 1'b1} << id : '0;
      bcd_vld <= fin;
      if (fin) begin
        bcd    <= core_q;
        bcd_id <= id;
        ptr    <= id == ID_W'(N_REQ - 1) ? '0 : id + 1'b1;
      end
    end
  bcd_dd_core u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .en   (shift_en),
    .din  (data[BIN_W*gnt_id+:BIN_W]),
    .q    (core_q),
    .last (last)
  );
endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Round-robin scheduler that shares one sequential binary-to-BCD (double-dabble) converter between up to four 8-bit requesters. It sits between the value sources (switch bank, counters, status registers) and the 7-segment multiplexing driver. It delivers a 12-bit three-digit BCD word tagged with the requester index and acknowledges each requester with a one-cycle pulse.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, `N_REQ`: per-requester level request; held high until the matching `ack`.
- `data`, input, `N_REQ*8`: flattened operands; requester i uses `data[8*i+7:8*i]`.
- `ack`, output, `N_REQ`: one-cycle pulse to the requester whose conversion completed.
- `bcd`, output, 12: result. Hundreds in [11:8], tens in [7:4], units in [3:0]. Holds the last result between conversions.
- `bcd_vld`, output, 1: one-cycle pulse, coincident with `ack`.
- `bcd_id`, output, `$clog2(N_REQ)`: index of the requester that owns `bcd`. Holds with `bcd`.
- `busy`, output, 1: high in SHIFT and DONE.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - If any `req` bit is high at the clock edge, grant the first set bit searching from `ptr` upward, modulo `N_REQ`.
  - On grant, load the shift register with {12'h000, data_i}, register the grant id, clear the bit counter and go to SHIFT.
  - If no `req` bit is high, stay in IDLE.
- SHIFT, one bit per cycle:
  - Add 3 to each BCD nibble that is 5 or greater.
  - Shift the 20-bit register left by one.
  - After the 8th shift, go to DONE.
- DONE:
  - Register `bcd` = shift register [19:8] and `bcd_id` = grant id.
  - Pulse `bcd_vld` and `ack[id]`.
  - Set `ptr` = (id+1) mod `N_REQ`.
  - Go to IDLE.
- The operand is sampled only at grant. Later changes to `data` or `req` do not affect the conversion in progress.
- If a requester drops `req` mid-conversion, the conversion still completes and `ack` still pulses.
- If `req` is still high in the IDLE cycle after `ack`, it counts as a new request. Round-robin order applies, so any other pending requester is served first.
- Simultaneous requests are resolved by `ptr` only. There is no fixed priority.
- Arithmetic: inputs range 0..255, so the hundreds digit is at most 2. No overflow is possible. No nibble of `bcd` ever exceeds 9.

## Timing
- Reset values:
  - `ack` = 0, `bcd` = 12'h000, `bcd_vld` = 0, `bcd_id` = 0, `busy` = 0.
  - FSM = IDLE, `ptr` = 0.
- Reset asserted mid-conversion aborts immediately. No `ack` is produced, and the requester must keep `req` high to be served after release.
- Per-conversion cycle count (edge E0 is the IDLE edge that grants):
  - E1..E8: the eight shifts.
  - E9: DONE registers the outputs.
  - `ack`, `bcd_vld`, `bcd` and `bcd_id` are valid in the cycle following E9. `ack` and `bcd_vld` drop at E10.
  - The next grant is possible at E11.
- Latency from grant edge to `ack` high is 9 cycles. Sustained throughput is one conversion per 11 cycles.
- `busy` is high from after E0 until E10.

## Structure
- Package `bcd_pkg` holds:
  - `BIN_W` = 8, `BCD_W` = 12, `SHIFT_W` = 20.
  - The state typedef `sched_state_t` {IDLE, SHIFT, DONE}.
  - Function `add3_nibbles(logic [11:0])`.
- Sub-module `bcd_dd_core` contains the shift register, the bit counter and start/done signalling.
- `bcd_conv_sched` contains the round-robin pointer, the grant logic, the FSM and the output registers.

## Test plan
- Reset: hold `rst_n` = 0 with random `req`/`data` → all outputs 0, `busy` = 0. After release with `req` = 0, outputs stay 0.
- Single request: `req[0]` = 1, `data0` = 8'd255 → `ack[0]` and `bcd_vld` high exactly 9 cycles after the grant edge, `bcd` = 12'h255, `bcd_id` = 0, one cycle wide. `bcd` still 12'h255 20 cycles later.
- Contention: after reset, `req` = 2'b11, `data0` = 8'd0, `data1` = 8'd99, both held through their acks and beyond:
  - First result is `bcd_id` = 0, `bcd` = 12'h000.
  - Second result is `bcd_id` = 1, `bcd` = 12'h099.
  - Results then alternate 0, 1, 0 with 11-cycle spacing.
- Operand capture: `req[1]` = 1 with `data1` = 8'd128. Change `data1` to 8'd7 three cycles after the grant and drop `req[1]` at shift 5 → `bcd` = 12'h128, and `ack[1]` still pulses.
- Reset mid-operation: pull `rst_n` low during shift 4 of a conversion on `data0` = 8'd200 → no `ack`, outputs 0. After release with `req[0]` held, `bcd` = 12'h200 after 9 cycles.
- Exhaustive: drive 0..255 through `req[0]` back-to-back → every `bcd` equals the decimal digits of the input, and every nibble is at most 9.
